snake_score_tx: RTL
===================

# snake_score_tx

Score-event transmitter for the Snake game; it drives the `increment`/`isDead` inputs of the high-score block. It samples per-move collision results from the game core and turns them into cleanly shaped `increment` pulses, with back-to-back food events queued. On death it drains queued points, holds `isDead`, then issues one score-clear pulse while `isDead` is still high.

## Interface
Parameters:
- `INC_HIGH`, 2: cycles `increment` is held high per pulse (≥1)
- `INC_LOW`, 2: minimum low cycles between pulses (≥1)
- `DEAD_HOLD`, 4: cycles `isDead` is high before the clear pulse (≥1)
- `PEND_W`, 3: width of the pending-point counter

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a game; honoured only in IDLE
- `step` in 1: one-cycle strobe; the snake moved this cycle
- `ate` in 1: head on food; qualified by `step`
- `hit_wall` in 1: head hit the wall; qualified by `step`
- `hit_self` in 1: head hit the body; qualified by `step`
- `increment` out 1: shaped point pulse to the score block
- `isDead` out 1: death level to the score block
- `playing` out 1: high in PLAY
- `pending` out PEND_W: queued, unsent points

## Operation
- States:
  - IDLE → PLAY on `start`.
  - PLAY → DRAIN on `step & (hit_wall | hit_self)`.
  - DRAIN → DEAD when `pending==0` and the emitter is idle with its low time satisfied.
  - DEAD → CLEAR after DEAD_HOLD cycles.
  - CLEAR → IDLE after the clear pulse's high plus low phases.
- Reset: state IDLE, `increment`=0, `isDead`=0, `playing`=0, `pending`=0. The emitter's low time counts as already satisfied.
- Point event: `step & ate` in PLAY, with no hit in the same cycle.
  - Hit and ate together: the hit wins and the point is discarded.
  - `step` outside PLAY is ignored.
- Emitter: a LOW/HIGH shaper. A launch is allowed when it is in LOW, has been low ≥ INC_LOW cycles, and a point is available.
  - An event arriving while the emitter is ready and `pending==0` launches directly (bypass) without touching `pending`.
  - Otherwise the event increments `pending`. A launch from the queue decrements it.
  - A queued launch and a new event in the same cycle leave `pending` unchanged.
- `pending` saturates at 2^PEND_W−1. Further events are dropped.
- DRAIN: new events are ignored; queued points continue to be emitted.
- DEAD: `isDead`=1 and the emitter is held.
- CLEAR: `isDead` stays 1. One `increment` pulse is sent (INC_HIGH high, then INC_LOW low), then `isDead` drops on the transition to IDLE.
  - Total `isDead` high time is DEAD_HOLD+INC_HIGH+INC_LOW cycles.
  - `increment` never rises in the same cycle `isDead` rises or falls.
- `start` outside IDLE is ignored.
- Reset mid-operation: all outputs go to 0 on the next edge. Queued points are lost.

## Timing
- Bypass latency: event sampled at edge k → `increment`=1 from edge k through edge k+INC_HIGH.
- Minimum pulse period is INC_HIGH+INC_LOW cycles.
- `pending` updates on the edge that samples the event.
- `playing` deasserts on the edge that samples the fatal `step`.
- All outputs are registered, with no combinational path from inputs.

## Configuration
- `SCORE_TX_OVF_EN` defined: adds output `dropped` (1 bit).
  - Set on any event lost to saturation; sticky until `rst` or the IDLE→PLAY transition.
- Not defined: there is no `dropped` port, and saturation silently discards events.

## Structure
- Package `snake_score_pkg`:
  - State enum: IDLE, PLAY, DRAIN, DEAD, CLEAR.
  - Default parameter constants.
- Sub-module `inc_pulse_gen`: pending counter, bypass, saturation and the LOW/HIGH shaper.
  - Inputs: `req`, `force_req` (for the clear pulse), `hold`.
  - Outputs: `increment`, `busy`, `pending`, `drop`.
- Top level holds the game FSM and the DEAD_HOLD counter.

## Test plan
(Defaults: INC_HIGH=2, INC_LOW=2, DEAD_HOLD=4, PEND_W=3.)
- Reset: assert `rst` 2 cycles → all outputs 0; `step&ate` without `start` → no pulse.
- Single point: `start`, then `step&ate` at edge k → `increment` high exactly 2 cycles starting after edge k; `pending` stays 0.
- Burst: `step&ate` on 3 consecutive cycles → 3 pulses at period 4; `pending` peaks at 2 and returns to 0.
- Saturation: 12 consecutive `step&ate` → exactly 10 pulses; `pending` reaches 7; `dropped`=1 only with `SCORE_TX_OVF_EN`.
- Death: with `pending`=2, `step&hit_wall&ate` → 2 pulses, then `isDead` high 8 cycles containing one 2-cycle `increment`; then IDLE with `playing`=0.
- Reset in DEAD: `rst` 2 cycles into DEAD → `isDead`=0, `increment`=0 next edge; `start` then works normally.

Source files
------------

// File: rtl/snake_score_pkg.sv
// Shared types and default parameters for the Snake score-event transmitter.
package snake_score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        DRAIN,
        DEAD,
        CLEAR
    } game_state_t;

    typedef enum logic {
        EM_LOW,
        EM_HIGH
    } emit_state_t;

    localparam int DEF_INC_HIGH  = 2;
    localparam int DEF_INC_LOW   = 2;
    localparam int DEF_DEAD_HOLD = 4;
    localparam int DEF_PEND_W    = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/inc_pulse_gen.sv
// Point queue plus LOW/HIGH shaper that turns point requests into increment pulses.
// Optional `drop` output exists only when SCORE_TX_OVF_EN is defined.
module inc_pulse_gen
    import snake_score_pkg::*;
#(
    parameter int INC_HIGH = DEF_INC_HIGH,
    parameter int INC_LOW  = DEF_INC_LOW,
    parameter int PEND_W   = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              force_req,
    input  logic              hold,
    output logic              increment,
    output logic              busy,
    output logic [PEND_W-1:0] pending
`ifdef SCORE_TX_OVF_EN
    ,
    output logic              drop
`endif
);

    localparam int CNT_W = $clog2(max_int(INC_HIGH, INC_LOW) + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    emit_state_t       em_state, em_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              inc_next;
    logic [PEND_W-1:0] pend_next;
    logic              ready, have_q, queue_pop, bypass, launch, drop_int;

    // cnt tracks completed high cycles in HIGH and completed low cycles in LOW
    assign ready     = (em_state == EM_LOW) && (cnt >= CNT_W'(INC_LOW));
    assign busy      = !ready;
    assign have_q    = (pending != '0);
    assign queue_pop = ready && !hold && have_q;
    assign bypass    = ready && !hold && !have_q && req;
    assign launch    = queue_pop || bypass || (ready && force_req);

`ifdef SCORE_TX_OVF_EN
    assign drop = drop_int;
`endif

    always_comb begin
        em_next   = em_state;
        cnt_next  = cnt;
        inc_next  = increment;
        pend_next = pending;
        drop_int  = 1'b0;

        if (req && !bypass) begin
            if (queue_pop) begin
                pend_next = pending;
            end else if (pending == PEND_MAX) begin
                drop_int = 1'b1;
            end else begin
                pend_next = pending + PEND_W'(1);
            end
        end else if (queue_pop) begin
            pend_next = pending - PEND_W'(1);
        end

        case (em_state)
            EM_LOW: begin
                if (launch) begin
                    em_next  = EM_HIGH;
                    cnt_next = CNT_W'(1);
                    inc_next = 1'b1;
                end else if (cnt < CNT_W'(INC_LOW)) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            EM_HIGH: begin
                if (cnt == CNT_W'(INC_HIGH)) begin
                    em_next  = EM_LOW;
                    cnt_next = CNT_W'(1);
                    inc_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                em_next  = EM_LOW;
                cnt_next = CNT_W'(INC_LOW);
                inc_next = 1'b0;
            end
        endcase
    end

    // Reset leaves the low phase already satisfied so the first point launches at once
    always_ff @(posedge clk) begin
        if (rst) begin
            em_state  <= EM_LOW;
            cnt       <= CNT_W'(INC_LOW);
            increment <= 1'b0;
            pending   <= '0;
        end else begin
            em_state  <= em_next;
            cnt       <= cnt_next;
            increment <= inc_next;
            pending   <= pend_next;
        end
    end

endmodule

// File: rtl/snake_score_tx.sv
// Snake score-event transmitter: game FSM, death hold timer and the point emitter.
// Defining SCORE_TX_OVF_EN adds the sticky `dropped` saturation flag.
module snake_score_tx
    import snake_score_pkg::*;
#(
    parameter int INC_HIGH  = DEF_INC_HIGH,
    parameter int INC_LOW   = DEF_INC_LOW,
    parameter int DEAD_HOLD = DEF_DEAD_HOLD,
    parameter int PEND_W    = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              ate,
    input  logic              hit_wall,
    input  logic              hit_self,
    output logic              increment,
    output logic              isDead,
    output logic              playing,
    output logic [PEND_W-1:0] pending
`ifdef SCORE_TX_OVF_EN
    ,
    output logic              dropped
`endif
);

    localparam int DW = $clog2(DEAD_HOLD + 1);

    game_state_t   state, state_next;
    logic [DW-1:0] dead_cnt, dead_cnt_next;
    logic          hit, point, force_req, hold, busy;

    assign hit     = hit_wall || hit_self;
    assign point   = (state == PLAY) && step && ate && !hit;
    assign hold    = (state == DEAD);
    assign playing = (state == PLAY);
    assign isDead  = (state == DEAD) || (state == CLEAR);

    // The clear pulse launches on the DEAD->CLEAR edge so isDead spans DEAD_HOLD+INC_HIGH+INC_LOW
    always_comb begin
        state_next    = state;
        dead_cnt_next = dead_cnt;
        force_req     = 1'b0;
        case (state)
            IDLE:  if (start) state_next = PLAY;
            PLAY:  if (step && hit) state_next = DRAIN;
            DRAIN: begin
                if (pending == '0 && !busy) begin
                    state_next    = DEAD;
                    dead_cnt_next = DW'(1);
                end
            end
            DEAD: begin
                if (dead_cnt == DW'(DEAD_HOLD)) begin
                    state_next = CLEAR;
                    force_req  = 1'b1;
                end else begin
                    dead_cnt_next = dead_cnt + DW'(1);
                end
            end
            CLEAR: if (!busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dead_cnt <= '0;
        end else begin
            state    <= state_next;
            dead_cnt <= dead_cnt_next;
        end
    end

`ifdef SCORE_TX_OVF_EN
    logic drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else if (state == IDLE && start) begin
            dropped <= 1'b0;
        end else if (drop) begin
            dropped <= 1'b1;
        end
    end
`endif

    inc_pulse_gen #(
        .INC_HIGH (INC_HIGH),
        .INC_LOW  (INC_LOW),
        .PEND_W   (PEND_W)
    ) u_emit (
        .clk       (clk),
        .rst       (rst),
        .req       (point),
        .force_req (force_req),
        .hold      (hold),
        .increment (increment),
        .busy      (busy),
        .pending   (pending)
`ifdef SCORE_TX_OVF_EN
        ,
        .drop      (drop)
`endif
    );

endmodule
